// File: rtl/kamus_imem_resp.sv
// Instruction-memory responder: one fetch at a time, response after LATENCY cycles, valid/ready return path.
// Redirect flush drops the in-flight fetch; a side write port loads the program image.
module kamus_imem_resp #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_addr_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [31:0]              rsp_instr_o,
  output logic [31:0]              rsp_addr_o,
  output logic                     rsp_err_o,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [31:0]              wr_data_i
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_instr_q;
  logic [31:0]   rsp_addr_q;
  logic          rsp_err_q;

  logic [31:0]   mem_q [DEPTH];

  logic [31:0]   off_d;
  logic [AW-1:0] idx_d;
  logic          err_d;
  logic [31:0]   instr_d;
  logic          accept;

  // Offset wraps for addresses below the base, so the span check alone
  // also catches them; the explicit compare keeps that intent obvious.
  always_comb begin
    off_d   = req_addr_i - BASE_ADDR;
    idx_d   = off_d[AW+1:2];
    err_d   = (|req_addr_i[1:0]) || (req_addr_i < BASE_ADDR) || (off_d >= SPAN);
    instr_d = err_d ? NOP : mem_q[idx_d];
  end

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_instr_o = rsp_instr_q;
  assign rsp_addr_o  = rsp_addr_q;
  assign rsp_err_o   = rsp_err_q;

  // Program-load port is independent of reset so the image can be loaded
  // while the core is held; the read above sees the pre-edge contents.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_instr_q <= 32'h0;
      rsp_addr_q  <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            rsp_addr_q  <= req_addr_i;
            rsp_err_q   <= err_d;
            rsp_instr_q <= instr_d;
            if (LATENCY == 1) begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (flush_i) begin
            state_q <= S_IDLE;
          end else if (cnt_q == 3'd0) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        S_RESP: begin
          if (flush_i || rsp_ready_i) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kamus_imem_resp.sv
// Directed bench: three responders (LATENCY 1, 3, 4) sharing clock, reset, flush and the load port.
module tb_kamus_imem_resp;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        wr_en_i;
  logic [9:0]  wr_addr_i;
  logic [31:0] wr_data_i;

  logic        rv   [3];
  logic        rr   [3];
  logic [31:0] ra   [3];
  logic        vv   [3];
  logic        rdy  [3];
  logic [31:0] ins  [3];
  logic [31:0] adr  [3];
  logic        err  [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    kamus_imem_resp #(
      .BASE_ADDR(32'h0),
      .DEPTH    (1024),
      .LATENCY  ((g == 0) ? 1 : ((g == 1) ? 3 : 4))
    ) u_dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req_valid_i(rv[g]),
      .req_ready_o(rr[g]),
      .req_addr_i (ra[g]),
      .rsp_valid_o(vv[g]),
      .rsp_ready_i(rdy[g]),
      .rsp_instr_o(ins[g]),
      .rsp_addr_o (adr[g]),
      .rsp_err_o  (err[g]),
      .flush_i    (flush_i),
      .wr_en_i    (wr_en_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic issue(input int k, input logic [31:0] a);
    rv[k] = 1'b1;
    ra[k] = a;
    tick();
    rv[k] = 1'b0;
  endtask

  task automatic complete(input int k);
    rdy[k] = 1'b1;
    tick();
    rdy[k] = 1'b0;
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    wr_en_i   = 1'b1;
    wr_addr_i = a;
    wr_data_i = d;
    tick();
    wr_en_i = 1'b0;
  endtask

  initial begin
    rst_i     = 1'b1;
    flush_i   = 1'b0;
    wr_en_i   = 1'b0;
    wr_addr_i = '0;
    wr_data_i = '0;
    for (int k = 0; k < 3; k++) begin
      rv[k] = 1'b0; ra[k] = '0; rdy[k] = 1'b0;
    end
    tick();

    // Reset state, with the program image loaded while reset is held
    chk("rst_ready",  {31'd0, rr[0]}, 32'd0);
    chk("rst_valid",  {31'd0, vv[1]}, 32'd0);
    chk("rst_instr",  ins[0], 32'h0);
    chk("rst_addr",   adr[2], 32'h0);
    chk("rst_err",    {31'd0, err[0]}, 32'd0);
    load(10'd0, 32'h0050_0093);
    load(10'd1, 32'hDEAD_BEEF);
    load(10'd2, 32'h1234_5678);
    load(10'd3, 32'h0000_000B);
    load(10'd1023, 32'hCAFE_F00D);
    rst_i = 1'b0;
    tick();
    chk("idle_ready", {31'd0, rr[0]}, 32'd1);

    // LATENCY=1 basic fetch
    issue(0, 32'h0);
    chk("l1_valid", {31'd0, vv[0]}, 32'd1);
    chk("l1_instr", ins[0], 32'h0050_0093);
    chk("l1_addr",  adr[0], 32'h0);
    chk("l1_err",   {31'd0, err[0]}, 32'd0);
    chk("l1_busy",  {31'd0, rr[0]}, 32'd0);
    complete(0);
    chk("l1_done_valid", {31'd0, vv[0]}, 32'd0);
    chk("l1_done_ready", {31'd0, rr[0]}, 32'd1);

    // LATENCY=3 with 5 stalled cycles
    issue(1, 32'h4);
    chk("l3_t0", {31'd0, vv[1]}, 32'd0);
    tick();
    chk("l3_t1", {31'd0, vv[1]}, 32'd0);
    tick();
    chk("l3_t2_valid", {31'd0, vv[1]}, 32'd1);
    chk("l3_t2_instr", ins[1], 32'hDEAD_BEEF);
    chk("l3_t2_addr",  adr[1], 32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("l3_hold_valid", {31'd0, vv[1]}, 32'd1);
      chk("l3_hold_instr", ins[1], 32'hDEAD_BEEF);
      chk("l3_hold_ready", {31'd0, rr[1]}, 32'd0);
    end
    complete(1);
    chk("l3_done_valid", {31'd0, vv[1]}, 32'd0);
    chk("l3_done_ready", {31'd0, rr[1]}, 32'd1);

    // Fault responses: misaligned, one past the end, and the last valid word
    issue(0, 32'h2);
    chk("mis_err",   {31'd0, err[0]}, 32'd1);
    chk("mis_instr", ins[0], 32'h0000_0013);
    chk("mis_addr",  adr[0], 32'h2);
    complete(0);
    issue(0, 32'h1000);
    chk("oor_err",   {31'd0, err[0]}, 32'd1);
    chk("oor_instr", ins[0], 32'h0000_0013);
    complete(0);
    issue(0, 32'hFFC);
    chk("top_err",   {31'd0, err[0]}, 32'd0);
    chk("top_instr", ins[0], 32'hCAFE_F00D);
    complete(0);

    // LATENCY=4: flush in the second WAIT cycle
    issue(2, 32'h8);
    tick();
    flush_i = 1'b1;
    chk("fl_wait_valid", {31'd0, vv[2]}, 32'd0);
    tick();
    flush_i = 1'b0;
    chk("fl_ready", {31'd0, rr[2]}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("fl_never_valid", {31'd0, vv[2]}, 32'd0);
      tick();
    end
    issue(2, 32'h8);
    chk("l4_t0", {31'd0, vv[2]}, 32'd0);
    tick();
    tick();
    chk("l4_t2", {31'd0, vv[2]}, 32'd0);
    tick();
    chk("l4_t3_valid", {31'd0, vv[2]}, 32'd1);
    chk("l4_t3_instr", ins[2], 32'h1234_5678);
    complete(2);

    // Flush while presenting, then flush in IDLE alongside a new request
    issue(0, 32'h0);
    flush_i = 1'b1;
    tick();
    chk("fl_resp_valid", {31'd0, vv[0]}, 32'd0);
    chk("fl_resp_ready", {31'd0, rr[0]}, 32'd1);
    rv[0] = 1'b1;
    ra[0] = 32'h4;
    tick();
    rv[0]   = 1'b0;
    flush_i = 1'b0;
    chk("fl_idle_valid", {31'd0, vv[0]}, 32'd1);
    chk("fl_idle_instr", ins[0], 32'hDEAD_BEEF);
    complete(0);

    // Same-cycle write to the fetched word returns old data
    rv[0]     = 1'b1;
    ra[0]     = 32'hC;
    wr_en_i   = 1'b1;
    wr_addr_i = 10'd3;
    wr_data_i = 32'h0000_000A;
    tick();
    rv[0]   = 1'b0;
    wr_en_i = 1'b0;
    chk("rw_old", ins[0], 32'h0000_000B);
    complete(0);
    issue(0, 32'hC);
    chk("rw_new", ins[0], 32'h0000_000A);
    complete(0);

    // Asynchronous reset while presenting a response
    issue(1, 32'h4);
    tick();
    tick();
    chk("ar_pre_valid", {31'd0, vv[1]}, 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("ar_valid", {31'd0, vv[1]}, 32'd0);
    chk("ar_ready", {31'd0, rr[1]}, 32'd0);
    chk("ar_instr", ins[1], 32'h0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("ar_rel_ready", {31'd0, rr[1]}, 32'd1);
    tick();
    chk("ar_rel_valid", {31'd0, vv[1]}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/kamus_imem_resp.md
Name: kamus_imem_resp

Overview:
Instruction-memory responder that sits on the L1I side of the fetch interface and serves fetch requests issued by the IF stage. It accepts one word-aligned fetch address at a time and returns the 32-bit instruction after a parameterised latency, using a valid/ready response handshake. It supports a branch/jump redirect flush that cancels the in-flight fetch, and has a side write port for boot-time program loading.

Parameters:
BASE_ADDR, 32'h0, byte address of word 0; matches the core boot address.
DEPTH, 1024, number of 32-bit words; power of two, at least 2.
LATENCY, 1, cycles from request acceptance to rsp_valid_o; legal range 1..8.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  reset, asynchronous, active-high.
req_valid_i  input  1  fetch request valid.
req_ready_o  output  1  responder can accept a request.
req_addr_i  input  32  fetch byte address (PC).
rsp_valid_o  output  1  response valid.
rsp_ready_i  input  1  IF consumes the response.
rsp_instr_o  output  32  fetched instruction word.
rsp_addr_o  output  32  address of the returned instruction.
rsp_err_o  output  1  fetch fault: misaligned or out of range.
flush_i  input  1  redirect; cancels the outstanding fetch.
wr_en_i  input  1  program-load write enable.
wr_addr_i  input  $clog2(DEPTH)  word index for the write.
wr_data_i  input  32  write data.

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE, rsp_valid_o=0, rsp_instr_o=0, rsp_addr_o=0, rsp_err_o=0, counter=0. req_ready_o=0 while rst_i is high. Memory contents are not cleared and are undefined until written.
- FSM states: IDLE, WAIT, RESP. req_ready_o = (state==IDLE) && !rst_i. rsp_valid_o = (state==RESP), driven from a register.
- Acceptance: a request is accepted when req_valid_i && req_ready_o at the rising edge.
- On acceptance:
  - Compute the word index as (req_addr_i-BASE_ADDR)>>2.
  - err = req_addr_i[1:0]!=0, or req_addr_i<BASE_ADDR, or req_addr_i>=BASE_ADDR+4*DEPTH.
  - Capture rsp_addr_o=req_addr_i and rsp_err_o=err.
  - Capture rsp_instr_o = err ? 32'h0000_0013 (NOP) : mem[index].
  - The read returns the value held before this edge's write: a same-cycle write to the same word gives old data.
- Transition from IDLE on acceptance: LATENCY==1 goes to RESP; otherwise goes to WAIT with cnt=LATENCY-2.
- WAIT: when cnt==0 go to RESP, else decrement cnt.
- Latency: if accepted at edge T, rsp_valid_o is first high after edge T+LATENCY-1. For LATENCY=1 this is the cycle immediately after acceptance.
- RESP:
  - Outputs stay stable while rsp_valid_o && !rsp_ready_i, with no cycle limit.
  - On rsp_ready_i the state goes to IDLE.
  - No new request is accepted in the same cycle. Minimum spacing between acceptances is LATENCY+1 cycles.
- flush_i:
  - In WAIT or RESP: the next state is IDLE, rsp_valid_o is low next cycle, and the cancelled response is never presented.
  - In RESP with rsp_ready_i and flush_i together: the handshake completes and the state goes to IDLE.
  - In IDLE: flush_i is ignored, so a simultaneous request is accepted normally (the flush applies to older fetches only).
- Writes: mem[wr_addr_i] <= wr_data_i on any edge with wr_en_i high, in any state, including while rst_i is high. A write does not alter a response already captured.
- Reset mid-operation: any state returns to IDLE immediately and the pending response is dropped.
- rsp_instr_o, rsp_addr_o and rsp_err_o hold their last values after a handshake; they are only meaningful while rsp_valid_o=1.

Test Plan:
1. LATENCY=1, load mem[0]=32'h00500093; request 32'h0 at edge T -> rsp_valid_o=1 after T with instr 32'h00500093, addr 0, err 0; rsp_ready_i=1 -> IDLE, req_ready_o=1 the next cycle.
2. LATENCY=3, request 32'h4 with mem[1]=32'hDEADBEEF -> rsp_valid_o first high after edge T+2; hold rsp_ready_i=0 for 5 cycles -> outputs stable and req_ready_o=0 throughout.
3. Request 32'h2 (misaligned), then 32'h1000 with DEPTH=1024 (out of range) -> each response has rsp_err_o=1 and rsp_instr_o=32'h00000013.
4. LATENCY=4, flush_i asserted in the second WAIT cycle -> rsp_valid_o never rises; req_ready_o=1 the next cycle; a new request to 32'h8 returns mem[2].
5. Write mem[3]=32'hA in the same cycle as accepting a request to 32'hC that previously held 32'hB -> response is 32'hB; a following fetch returns 32'hA.
6. Assert rst_i asynchronously while in RESP -> rsp_valid_o=0 and req_ready_o=0 immediately, with no clock edge; after release, IDLE and no stale response.
